// File: rtl/sync_fifo_pro_if.sv
// Producer/consumer bundle for sync_fifo_pro: write side, read side, status and sticky error flags.
// master drives requests and write data; slave is the FIFO itself.
interface sync_fifo_pro_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  almost_empty;
   logic [CNT_WIDTH-1:0]  level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, almost_full, rd_data, rd_valid, empty, almost_empty, level, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, almost_full, rd_data, rd_valid, empty, almost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO, any DEPTH >= 2; standard read has 1-cycle data latency, FWFT shows the head combinationally.
// Writes while full and reads while empty are dropped and latched into sticky overflow/underflow.
module sync_fifo_pro #(
   parameter int    DEPTH      = 16,
   parameter int    DATA_WIDTH = 32,
   parameter int    CNT_WIDTH  = $clog2(DEPTH + 1),
   parameter bit    FWFT       = 1'b0,
   parameter int    AF_THRESH  = DEPTH - 2,
   parameter int    AE_THRESH  = 2,
   parameter string RAM_TYPE   = "distributed"
) (
   input  logic           clk,
   input  logic           rst,
   sync_fifo_pro_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]     PTR_MAX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
   localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_pro: DEPTH must be >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_pro: AF_THRESH must lie in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_pro: AE_THRESH must lie in 0..DEPTH-1");
   end
   if (FWFT && RAM_TYPE == "block") begin : g_bad_ram
      $error("sync_fifo_pro: block RAM cannot provide a fall-through read port");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_WIDTH-1:0]  level_q;
   logic [CNT_WIDTH-1:0]  level_nxt;
   logic                  full_q;
   logic                  empty_q;
   logic                  af_q;
   logic                  ae_q;
   logic                  ovf_q;
   logic                  unf_q;
   logic                  wr_acc;
   logic                  rd_acc;

   // Accept decisions use the registered flags only, so a simultaneous pop never frees room for a push.
   assign wr_acc = bus.wr_en & ~full_q;
   assign rd_acc = bus.rd_en & ~empty_q;

   always_comb begin
      level_nxt = level_q;
      if (wr_acc && !rd_acc) begin
         level_nxt = level_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
         level_nxt = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
         end
         level_q <= level_nxt;
         full_q  <= (level_nxt == DEPTH_C);
         empty_q <= (level_nxt == '0);
         af_q    <= (level_nxt >= AF_C);
         ae_q    <= (level_nxt <= AE_C);
         if (bus.wr_en && full_q) begin
            ovf_q <= 1'b1;
         end
         if (bus.rd_en && empty_q) begin
            unf_q <= 1'b1;
         end
      end
   end

   // Storage is never cleared; reset only discards it by zeroing the pointers.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   if (FWFT) begin : g_fwft
      assign bus.rd_data  = mem[rd_ptr];
      assign bus.rd_valid = ~empty_q;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
               rd_data_q <= mem[rd_ptr];
            end
         end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
   end

   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.level        = level_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_pro.sv
// Five FIFO configurations run side by side against queue-based reference models,
// with directed scenarios pinned by literal expectations followed by a long randomized phase.
module tb_sync_fifo_pro;
   localparam int NI = 5;
   localparam int DEP_T [NI] = '{16, 5, 4, 8, 4};
   localparam bit FW_T  [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam int AF_T  [NI] = '{14, 4, 2, 6, 3};
   localparam int AE_T  [NI] = '{2, 1, 2, 2, 1};

   typedef struct packed {
      logic        full;
      logic        af;
      logic        empty;
      logic        ae;
      logic        ovf;
      logic        unf;
      logic        rvld;
      logic [4:0]  level;
      logic [31:0] rdata;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   fails  = 0;
   logic cmp_on = 1'b0;

   logic        rst_s     [NI];
   logic        wr_en_s   [NI];
   logic [31:0] wr_data_s [NI];
   logic        rd_en_s   [NI];
   obs_t        obs_dut   [NI];
   obs_t        obs_mdl   [NI];
   logic        care      [NI];

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int D  = DEP_T[g];
      localparam int CW = $clog2(D + 1);

      sync_fifo_pro_if #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) bus ();

      assign bus.wr_en   = wr_en_s[g];
      assign bus.wr_data = wr_data_s[g];
      assign bus.rd_en   = rd_en_s[g];

      sync_fifo_pro #(
         .DEPTH(D), .DATA_WIDTH(32), .FWFT(FW_T[g]),
         .AF_THRESH(AF_T[g]), .AE_THRESH(AE_T[g])
      ) dut (
         .clk(clk),
         .rst(rst_s[g]),
         .bus(bus)
      );

      assign obs_dut[g] = '{bus.full, bus.almost_full, bus.empty, bus.almost_empty,
                            bus.overflow, bus.underflow, bus.rd_valid, 5'(bus.level), bus.rd_data};

      // Reference: the FIFO contents as a queue; status derived from its size.
      logic [31:0] q [$];
      logic        m_ovf, m_unf, m_rvld;
      logic [31:0] m_rdat;
      logic [31:0] h;
      int          n;
      obs_t        mdl;
      logic        mdl_care;

      always @(posedge clk) begin
         if (rst_s[g]) begin
            q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_rvld = 1'b0;
            m_rdat = '0;
         end else begin
            n      = q.size();
            m_rvld = 1'b0;
            if (wr_en_s[g] && n == D) m_ovf = 1'b1;
            if (rd_en_s[g] && n == 0) m_unf = 1'b1;
            if (rd_en_s[g] && n != 0) begin
               h = q.pop_front();
               if (!FW_T[g]) begin
                  m_rdat = h;
                  m_rvld = 1'b1;
               end
            end
            if (wr_en_s[g] && n != D) q.push_back(wr_data_s[g]);
         end
         n = q.size();
         if (FW_T[g]) begin
            m_rvld = (n != 0);
            m_rdat = (n != 0) ? q[0] : '0;
         end
         mdl.full  = (n == D);
         mdl.af    = (n >= AF_T[g]);
         mdl.empty = (n == 0);
         mdl.ae    = (n <= AE_T[g]);
         mdl.ovf   = m_ovf;
         mdl.unf   = m_unf;
         mdl.rvld  = m_rvld;
         mdl.level = 5'(n);
         mdl.rdata = m_rdat;
         mdl_care  = !FW_T[g] || (n != 0);
      end

      assign obs_mdl[g] = mdl;
      assign care[g]    = mdl_care;
   end

   obs_t d_o, m_o;
   always @(negedge clk) begin
      if (cmp_on) begin
         for (int i = 0; i < NI; i++) begin
            d_o = obs_dut[i];
            m_o = obs_mdl[i];
            if (!care[i]) begin
               d_o.rdata = '0;
               m_o.rdata = '0;
            end
            checks++;
            if (d_o !== m_o) begin
               fails++;
               $display("FAIL model_cmp inst%0d t=%0t: dut f/af/e/ae/ov/un/v=%b%b%b%b%b%b%b lvl=%0d data=%h, model %b%b%b%b%b%b%b lvl=%0d data=%h",
                        i, $time, d_o.full, d_o.af, d_o.empty, d_o.ae, d_o.ovf, d_o.unf, d_o.rvld, d_o.level, d_o.rdata,
                        m_o.full, m_o.af, m_o.empty, m_o.ae, m_o.ovf, m_o.unf, m_o.rvld, m_o.level, m_o.rdata);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Drive one cycle of requests on instance g; returns at the following falling edge.
   task automatic step(input int g, input bit w, input logic [31:0] d, input bit r);
      wr_en_s[g]   = w;
      wr_data_s[g] = d;
      rd_en_s[g]   = r;
      @(negedge clk);
      wr_en_s[g] = 1'b0;
      rd_en_s[g] = 1'b0;
   endtask

   int wb;

   initial begin
      for (int g = 0; g < NI; g++) begin
         rst_s[g]     = 1'b1;
         wr_en_s[g]   = 1'b0;
         wr_data_s[g] = '0;
         rd_en_s[g]   = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int g = 0; g < NI; g++) rst_s[g] = 1'b0;
      cmp_on = 1'b1;

      // Reset state, DEPTH=16
      chk("rst_empty",    32'(obs_dut[0].empty), 32'd1);
      chk("rst_full",     32'(obs_dut[0].full),  32'd0);
      chk("rst_level",    32'(obs_dut[0].level), 32'd0);
      chk("rst_ae",       32'(obs_dut[0].ae),    32'd1);
      chk("rst_ovf",      32'(obs_dut[0].ovf),   32'd0);
      chk("rst_rvld",     32'(obs_dut[0].rvld),  32'd0);
      chk("rst_rdata",    obs_dut[0].rdata,      32'd0);

      // Wrap with DEPTH=5
      for (int k = 1; k <= 5; k++) step(1, 1'b1, 32'(k), 1'b0);
      chk("d5_full",  32'(obs_dut[1].full),  32'd1);
      chk("d5_level", 32'(obs_dut[1].level), 32'd5);
      for (int k = 1; k <= 2; k++) begin
         step(1, 1'b0, '0, 1'b1);
         chk("d5_rd_a", obs_dut[1].rdata, 32'(k));
         chk("d5_vld_a", 32'(obs_dut[1].rvld), 32'd1);
      end
      step(1, 1'b1, 32'd6, 1'b0);
      step(1, 1'b1, 32'd7, 1'b0);
      for (int k = 3; k <= 7; k++) begin
         step(1, 1'b0, '0, 1'b1);
         chk("d5_rd_b", obs_dut[1].rdata, 32'(k));
      end
      chk("d5_empty", 32'(obs_dut[1].empty), 32'd1);
      @(negedge clk);
      chk("d5_vld_drop", 32'(obs_dut[1].rvld), 32'd0);

      // Overflow with DEPTH=4
      for (int k = 0; k < 4; k++) step(2, 1'b1, 32'hA1 + 32'(k), 1'b0);
      step(2, 1'b1, 32'hAA, 1'b1);
      chk("ovf_level", 32'(obs_dut[2].level), 32'd3);
      chk("ovf_flag",  32'(obs_dut[2].ovf),   32'd1);
      chk("ovf_rdata", obs_dut[2].rdata,      32'hA1);
      for (int k = 1; k < 4; k++) begin
         step(2, 1'b0, '0, 1'b1);
         chk("ovf_drain", obs_dut[2].rdata, 32'hA1 + 32'(k));
      end
      chk("ovf_sticky", 32'(obs_dut[2].ovf), 32'd1);

      // Underflow: read+write into empty
      step(2, 1'b1, 32'h55, 1'b1);
      chk("unf_flag",  32'(obs_dut[2].unf),   32'd1);
      chk("unf_level", 32'(obs_dut[2].level), 32'd1);
      chk("unf_novld", 32'(obs_dut[2].rvld),  32'd0);
      step(2, 1'b0, '0, 1'b1);
      chk("unf_rdata", obs_dut[2].rdata,      32'h55);
      chk("unf_vld",   32'(obs_dut[2].rvld),  32'd1);
      rst_s[2] = 1'b1;
      @(negedge clk);
      rst_s[2] = 1'b0;
      chk("rst_clr_ovf", 32'(obs_dut[2].ovf), 32'd0);
      chk("rst_clr_unf", 32'(obs_dut[2].unf), 32'd0);

      // Thresholds, DEPTH=8 AF=6 AE=2 (FWFT)
      for (int k = 1; k <= 8; k++) begin
         step(3, 1'b1, 32'h100 + 32'(k), 1'b0);
         chk("thr_fill_af", 32'(obs_dut[3].af), (k >= 6) ? 32'd1 : 32'd0);
         chk("thr_fill_ae", 32'(obs_dut[3].ae), (k <= 2) ? 32'd1 : 32'd0);
      end
      for (int k = 7; k >= 0; k--) begin
         step(3, 1'b0, '0, 1'b1);
         chk("thr_drain_af", 32'(obs_dut[3].af), (k >= 6) ? 32'd1 : 32'd0);
         chk("thr_drain_ae", 32'(obs_dut[3].ae), (k <= 2) ? 32'd1 : 32'd0);
         if (k > 0) chk("thr_head", obs_dut[3].rdata, 32'h100 + 32'(9 - k));
      end

      // FWFT, DEPTH=4
      step(4, 1'b1, 32'h11, 1'b0);
      chk("fwft_empty", 32'(obs_dut[4].empty), 32'd0);
      chk("fwft_data",  obs_dut[4].rdata,      32'h11);
      step(4, 1'b1, 32'h22, 1'b1);
      chk("fwft_level", 32'(obs_dut[4].level), 32'd1);
      chk("fwft_data2", obs_dut[4].rdata,      32'h22);

      // Randomized traffic on all instances, alternating fill-biased and drain-biased phases
      for (int c = 0; c < 4000; c++) begin
         wb = ((c / 250) % 2 == 1) ? 75 : 30;
         for (int g = 0; g < NI; g++) begin
            rst_s[g]     = ($urandom_range(0, 299) == 0);
            wr_en_s[g]   = ($urandom_range(0, 99) < wb);
            wr_data_s[g] = $urandom;
            rd_en_s[g]   = ($urandom_range(0, 99) < 100 - wb);
         end
         @(negedge clk);
      end
      for (int g = 0; g < NI; g++) begin
         rst_s[g]   = 1'b0;
         wr_en_s[g] = 1'b0;
         rd_en_s[g] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      cmp_on = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
